// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: requester indices and arbiter state.
package dmem_arb_pkg;

  localparam int unsigned REQ_WB   = 0;
  localparam int unsigned REQ_SRC0 = 1;
  localparam int unsigned REQ_SRC1 = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDRESP
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational N-way round-robin priority encoder: first asserted req at or after ptr wins.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    // Scan from the farthest offset back to ptr so the nearest requester is written last.
    for (int unsigned k = N; k > 0; k--) begin
      cand = PW'((32'(ptr) + k - 1) % N);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter with round-robin grant and one-cycle read response.
// Optional macro WB_PRIORITY_EN gives write-back (requester 0) absolute priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  output logic [N_REQ-1:0]    stall
);

  localparam int unsigned PW = $clog2(N_REQ);

  arb_state_t        state_q, state_d;
  logic [PW-1:0]     rr_ptr, owner_q, win, pick_idx;
  logic [N_REQ-1:0]  pick_req, pick_gnt, gnt_c;
  logic              granted, advance;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req (pick_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
`ifdef WB_PRIORITY_EN
    pick_req = req & ~(N_REQ'(1) << REQ_WB);
`else
    pick_req = req;
`endif
    gnt_c = pick_gnt;
    win   = pick_idx;
`ifdef WB_PRIORITY_EN
    if (req[REQ_WB]) begin
      gnt_c         = '0;
      gnt_c[REQ_WB] = 1'b1;
      win           = PW'(REQ_WB);
    end
    advance = granted && (32'(win) != REQ_WB);
`else
    advance = granted;
`endif
  end

  always_comb begin
    granted   = ~rst & (|gnt_c);
    gnt       = granted ? gnt_c : '0;
    stall     = rst ? '0 : (req & ~gnt_c);
    mem_en    = granted;
    mem_we    = granted & req_we[win];
    mem_addr  = granted ? req_addr[win*AW +: AW] : '0;
    mem_wdata = granted ? req_wdata[win*DW +: DW] : '0;

    // state_q records last cycle's activity; RDRESP is the registered read-response flag.
    if (granted && !req_we[win]) state_d = RDRESP;
    else if (granted)            state_d = ACCESS;
    else                         state_d = IDLE;

    rvalid = '0;
    rdata  = '0;
    if (!rst && state_q == RDRESP) begin
      rvalid[owner_q] = 1'b1;
      rdata           = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (granted) owner_q <= win;
      if (advance) rr_ptr <= (32'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed grant checks plus read-response queue.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, req_we;
  logic [8:0]  req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  gnt, rvalid, stall;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [2:0]  mem_addr;

  dmem_arbiter #(.N_REQ(3), .AW(3), .DW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [8];
  logic [7:0] ref_mem [8];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic [2:0] rv;
    logic [7:0] d;
    int         cyc;
  } resp_t;

  resp_t sb[$];
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  int    exp_ptr = 0;
  logic [2:0] exp_gnt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] model_pick(input logic [2:0] r, input int p);
    logic [2:0] m;
    m = r;
`ifdef WB_PRIORITY_EN
    if (r[0]) return 3'b001;
    m[0] = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      if (m[(p + k) % 3]) return 3'b001 << ((p + k) % 3);
    end
    return 3'b000;
  endfunction

  function automatic logic [8:0] pa(input int a0, input int a1, input int a2);
    return {3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // One bus cycle: drive just after posedge, update reference model, leave outputs settled.
  task automatic cycle(input logic [2:0] r, input logic [2:0] we, input logic [8:0] a,
                       input logic [23:0] wd, input logic rs);
    int idx;
    @(posedge clk);
    #1;
    req = r; req_we = we; req_addr = a; req_wdata = wd; rst = rs;
    if (rs) begin
      sb.delete();
      exp_ptr = 0;
      exp_gnt = 3'b000;
    end else begin
      exp_gnt = model_pick(r, exp_ptr);
      if (exp_gnt != 3'b000) begin
        idx = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
        if (we[idx]) ref_mem[a[idx*3 +: 3]] = wd[idx*8 +: 8];
        else sb.push_back('{rv: exp_gnt, d: ref_mem[a[idx*3 +: 3]], cyc: cyc + 1});
`ifdef WB_PRIORITY_EN
        if (idx != 0) exp_ptr = (idx + 1) % 3;
`else
        exp_ptr = (idx + 1) % 3;
`endif
      end
    end
    #1;
  endtask

  // Response monitor: every cycle either the queued read response or no rvalid at all.
  always @(negedge clk) begin
    resp_t e;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      tests++;
      if (rvalid !== e.rv || rdata !== e.d) begin
        fails++;
        $display("FAIL resp cyc%0d: rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                 cyc, rvalid, rdata, e.rv, e.d);
      end
    end else begin
      tests++;
      if (rvalid !== 3'b000) begin
        fails++;
        $display("FAIL no_resp cyc%0d: rvalid=%b, want 000", cyc, rvalid);
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(3'b111, 3'b000, pa(1, 2, 4), 24'h0, 1'b1);
      tests++;
      if (gnt !== 3'b000 || mem_en !== 1'b0 || mem_we !== 1'b0 || stall !== 3'b000 ||
          mem_addr !== 3'd0 || mem_wdata !== 8'h00 || rdata !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold: gnt=%b en=%b we=%b stall=%b addr=%0d wd=%h rd=%h, want all zero",
                 gnt, mem_en, mem_we, stall, mem_addr, mem_wdata, rdata);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(3'b000, 3'b000, 9'h0, 24'h0, 1'b0);
      tests++;
      if (gnt !== 3'b000 || mem_en !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle: gnt=%b mem_en=%b, want 000/0", gnt, mem_en);
      end
    end
  endtask

  task automatic test_rotation();
    logic [2:0] want [3];
`ifdef WB_PRIORITY_EN
    want = '{3'b001, 3'b001, 3'b001};
`else
    want = '{3'b001, 3'b010, 3'b100};
`endif
    for (int i = 0; i < 3; i++) begin
      cycle(3'b111, 3'b000, pa(1, 2, 4), 24'h0, 1'b0);
      tests++;
      if (gnt !== want[i] || stall !== ~want[i] || mem_en !== 1'b1 || mem_we !== 1'b0) begin
        fails++;
        $display("FAIL rotation%0d: gnt=%b stall=%b en=%b we=%b, want gnt=%b stall=%b en=1 we=0",
                 i, gnt, stall, mem_en, mem_we, want[i], ~want[i]);
      end
    end
    cycle(3'b000, 3'b000, 9'h0, 24'h0, 1'b0);
  endtask

  task automatic test_single_read();
    cycle(3'b010, 3'b000, pa(0, 3, 0), 24'h0, 1'b0);
    tests++;
    if (gnt !== 3'b010 || mem_addr !== 3'd3 || mem_en !== 1'b1 || mem_we !== 1'b0 || stall !== 3'b000) begin
      fails++;
      $display("FAIL single_read: gnt=%b addr=%0d en=%b we=%b stall=%b, want 010/3/1/0/000",
               gnt, mem_addr, mem_en, mem_we, stall);
    end
    cycle(3'b000, 3'b000, 9'h0, 24'h0, 1'b0);
    tests++;
    if (gnt !== 3'b000 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: gnt=%b en=%b, want 000/0", gnt, mem_en);
    end
  endtask

  task automatic test_write_then_read();
    cycle(3'b001, 3'b001, pa(5, 0, 0), 24'h00003C, 1'b0);
    tests++;
    if (gnt !== 3'b001 || mem_we !== 1'b1 || mem_addr !== 3'd5 || mem_wdata !== 8'h3C) begin
      fails++;
      $display("FAIL wr_grant: gnt=%b we=%b addr=%0d wd=%h, want 001/1/5/3c",
               gnt, mem_we, mem_addr, mem_wdata);
    end
    cycle(3'b100, 3'b000, pa(0, 0, 5), 24'h0, 1'b0);
    tests++;
    if (gnt !== 3'b100 || mem_we !== 1'b0 || mem_addr !== 3'd5) begin
      fails++;
      $display("FAIL rd_after_wr: gnt=%b we=%b addr=%0d, want 100/0/5", gnt, mem_we, mem_addr);
    end
    cycle(3'b000, 3'b000, 9'h0, 24'h0, 1'b0);
  endtask

  task automatic test_withdraw();
    cycle(3'b011, 3'b000, pa(0, 6, 7), 24'h0, 1'b0);
    tests++;
    if (gnt !== 3'b001 || stall !== 3'b010) begin
      fails++;
      $display("FAIL contend: gnt=%b stall=%b, want 001/010", gnt, stall);
    end
    cycle(3'b000, 3'b000, pa(0, 6, 7), 24'h0, 1'b0);
    tests++;
    if (gnt !== 3'b000 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL withdraw: gnt=%b en=%b, want 000/0", gnt, mem_en);
    end
    cycle(3'b110, 3'b000, pa(0, 6, 7), 24'h0, 1'b0);
    tests++;
    if (gnt !== 3'b010 || mem_addr !== 3'd6 || stall !== 3'b100) begin
      fails++;
      $display("FAIL after_withdraw: gnt=%b addr=%0d stall=%b, want 010/6/100", gnt, mem_addr, stall);
    end
    cycle(3'b000, 3'b000, 9'h0, 24'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    cycle(3'b010, 3'b000, pa(0, 3, 0), 24'h0, 1'b0);
    tests++;
    if (gnt !== 3'b010) begin
      fails++;
      $display("FAIL mid_grant: gnt=%b, want 010", gnt);
    end
    cycle(3'b000, 3'b000, 9'h0, 24'h0, 1'b1);
    tests++;
    if (rvalid !== 3'b000 || rdata !== 8'h00) begin
      fails++;
      $display("FAIL mid_rst: rvalid=%b rdata=%h, want 000/00", rvalid, rdata);
    end
    cycle(3'b000, 3'b000, 9'h0, 24'h0, 1'b0);
    cycle(3'b110, 3'b000, pa(0, 2, 4), 24'h0, 1'b0);
    tests++;
    if (gnt !== 3'b010) begin
      fails++;
      $display("FAIL post_rst_first: gnt=%b, want 010", gnt);
    end
    cycle(3'b000, 3'b000, 9'h0, 24'h0, 1'b0);
    cycle(3'b000, 3'b000, 9'h0, 24'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 8; i++) begin
      mem[i]     = 8'(8'h10 + i * 8'h11);
      ref_mem[i] = 8'(8'h10 + i * 8'h11);
    end
    mem[3]     = 8'hA5;
    ref_mem[3] = 8'hA5;

    test_reset();
    test_rotation();
    test_single_read();
    test_write_then_read();
    test_withdraw();
    test_reset_mid();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between up to N_REQ requesters: pipeline operand-fetch port 0, operand-fetch port 1 and write-back.
- Each requester uses a req/gnt handshake. The arbiter grants at most one access per cycle, drives the memory port and returns read data one cycle after the grant.
- It sits between the pipeline stages and the dmem instance, replacing direct stage-to-memory wiring.

Parameters:
- N_REQ, 3, number of requesters (2..8); index 0 = write-back, 1 = operand src0, 2 = operand src1.
- AW, 3, data memory address width (8 entries).
- DW, 8, data word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester access request.
- req_we  in  N_REQ  per-requester write enable (1 = write, 0 = read).
- req_addr  in  N_REQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_wdata  in  N_REQ*DW  packed write data, same packing as req_addr.
- gnt  out  N_REQ  one-hot grant; same-cycle response to req.
- rvalid  out  N_REQ  one-hot; read data valid for requester i.
- rdata  out  DW  read data returned to the requester flagged by rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; registered by memory, valid the cycle after mem_en with mem_we=0.
- stall  out  N_REQ  req[i] & ~gnt[i]; used by the pipeline to hold the stage.

Behaviour:
- Reset (rst=1 at edge): rr_ptr=0, rvalid_q=0, owner_q=0. While rst=1, gnt=0, mem_en=0, mem_we=0, rvalid=0, stall=0, mem_addr=0, mem_wdata=0, rdata=0.
- Arbitration is combinational each cycle. Scan indices starting at rr_ptr and wrapping modulo N_REQ; the first i with req[i]=1 wins.
- Outputs for the winner: gnt[i]=1, mem_en=1, mem_we=req_we[i], mem_addr/mem_wdata from slice i.
- If no req is asserted: gnt=0, mem_en=0, and rr_ptr is held.
- rr_ptr update: after a grant to i, rr_ptr <= (i+1) mod N_REQ. Wrap from N_REQ-1 goes to 0.
- Requester rule: hold req, req_we, req_addr and req_wdata stable until the cycle gnt[i]=1. Drop or change them the cycle after. Deasserting req before gnt is legal (request withdrawn, no access).
- Read latency: a read granted in cycle t gives rvalid[i]=1 and rdata=mem_rdata in cycle t+1 only.
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle; read pipelining is one deep (rvalid_q/owner_q).
- Ordering: accesses take effect in grant order. A read granted the cycle after a write to the same address returns the new data; the memory is write-first for the next access.
- States:
  - IDLE: no grant this cycle.
  - ACCESS: grant issued.
  - RDRESP: a registered flag, asserted the cycle after a read grant. It may overlap ACCESS of the next grant.
- Reset mid-operation: a pending read response is discarded (rvalid stays 0) and the pointer returns to 0.
- N_REQ=2 is the degenerate case: behaves as alternating priority.

Optional Feature:
- Macro WB_PRIORITY_EN.
- Defined: requester 0 (write-back) wins whenever req[0]=1, regardless of rr_ptr. Round-robin applies among the others only, and rr_ptr advances only on grants to indices ≥1. This avoids write-back stalls that would freeze the pipeline.
- Undefined: pure round-robin across all requesters, as above.

Decomposition:
- Package dmem_arb_pkg: requester index localparams REQ_WB=0, REQ_SRC0=1, REQ_SRC1=2; arbiter state enum (IDLE, ACCESS, RDRESP) for debug visibility.
- One sub-module, rr_pick: combinational N-way round-robin priority encoder (inputs req, ptr; outputs one-hot gnt and winner index). It is reused by other shared-resource arbiters.
- Everything else lives in dmem_arbiter.

Test Plan:
- Reset release, no req for 5 cycles -> gnt=0, mem_en=0, rvalid=0, rr_ptr=0 throughout.
- req[1] read addr 3 (mem[3]=8'hA5) -> gnt=3'b010 same cycle, mem_addr=3. Next cycle rvalid=3'b010, rdata=8'hA5.
- req=3'b111 held for 3 cycles, all reads -> gnts 001, 010, 100 in order. rvalid follows one cycle behind each, and each rdata matches its own address.
- Cycle t: req[0] writes 8'h3C to addr 5. Cycle t+1: req[2] reads addr 5 -> rvalid[2] at t+2 with rdata=8'h3C.
- WB_PRIORITY_EN defined, req=3'b111 continuously, req[0] reasserted each cycle -> gnt=001 every cycle, stall=3'b110. Undefined -> rotation 001, 010, 100.
- Read granted at t, rst=1 at t+1 -> rvalid stays 0 at t+1 and t+2. After reset, the first grant goes to the lowest asserted index.
